// File: rtl/cnn_sched_pkg.sv
// Shared defaults and round-robin selection helper for the CNN core scheduler.
package cnn_sched_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_TAG_W     = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_JOB_DEPTH = 4;
  localparam int CORE_IDX_W    = $clog2(DEF_NUM_CORES);

  // Selection helper works on the widest supported core count; callers zero-extend.
  localparam int MAX_CORES = 8;
  localparam int SEL_W     = 3;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_sel_t;

  // First set bit of mask at or after start, wrapping within num entries.
  function automatic rr_sel_t rr_first(input logic [MAX_CORES-1:0] mask,
                                       input logic [SEL_W-1:0]     start,
                                       input int                   num);
    rr_sel_t          sel;
    logic [SEL_W-1:0] cand;
    sel = '0;
    for (int k = 0; k < MAX_CORES; k++) begin
      cand = SEL_W'((int'(start) + k) % num);
      if (k < num && !sel.found && mask[cand]) begin
        sel.found = 1'b1;
        sel.idx   = cand;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sched_job_fifo.sv
// Job tag FIFO with registered ready (not full) and empty flags.
module sched_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ready_q, ready_d;
  logic             empty_q, empty_d;
  logic             push, pop_ok;

  // Pointer, count and flag update; a pop never re-opens the FIFO in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push     = push_req & ready_q;
    pop_ok   = pop & ~empty_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push && pop_ok) count_d = count_q - 1'b1;
    ready_d = (count_d != (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  // State registers; ready stays low while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      empty_q  <= empty_d;
    end
  end

  assign ready = ready_q;
  assign empty = empty_q;
  assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cnn_core_scheduler.sv
// Round-robin job dispatcher and result collector for parallel CNN cores.
module cnn_core_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int JOB_DEPTH = DEF_JOB_DEPTH,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [TAG_W-1:0]            job_tag,
  output logic [NUM_CORES-1:0]        core_enable,
  output logic [NUM_CORES-1:0]        core_clear,
  output logic [NUM_CORES*TAG_W-1:0]  core_tag,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES*DATA_W-1:0] core_value,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [TAG_W-1:0]            res_tag,
  output logic [DATA_W-1:0]           res_value,
  output logic [NUM_CORES-1:0]        busy,
  output logic                        err_spurious
);

  localparam int CIW = $clog2(NUM_CORES);

  logic              fifo_ready, fifo_empty, fifo_pop;
  logic [TAG_W-1:0]  fifo_head;

  logic [NUM_CORES-1:0] core_enable_q, core_enable_d;
  logic [NUM_CORES-1:0] core_clear_q, core_clear_d;
  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [NUM_CORES-1:0] pend_q, pend_d;
  logic [CIW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CIW-1:0]       res_ptr_q, res_ptr_d;
  logic [TAG_W-1:0]     core_tag_q [NUM_CORES];
  logic [TAG_W-1:0]     core_tag_d [NUM_CORES];
  logic [DATA_W-1:0]    res_buf_q [NUM_CORES];
  logic [DATA_W-1:0]    res_buf_d [NUM_CORES];
  logic                 res_valid_q, res_valid_d;
  logic [TAG_W-1:0]     res_tag_q, res_tag_d;
  logic [DATA_W-1:0]    res_value_q, res_value_d;
  logic                 err_q, err_d;

  logic [DATA_W-1:0]    core_val [NUM_CORES];
  logic [MAX_CORES-1:0] free_mask, pend_mask;
  rr_sel_t              disp_sel, res_sel;
  logic [CIW-1:0]       disp_idx, res_idx;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core_io
    assign core_tag[g*TAG_W +: TAG_W] = core_tag_q[g];
    assign core_val[g]                = core_value[g*DATA_W +: DATA_W];
  end

  sched_job_fifo #(
    .DEPTH (JOB_DEPTH),
    .WIDTH (TAG_W)
  ) u_job_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_req (job_valid),
    .pop      (fifo_pop),
    .din      (job_tag),
    .ready    (fifo_ready),
    .empty    (fifo_empty),
    .dout     (fifo_head)
  );

  // Dispatch, result selection, completion capture and core release.
  always_comb begin
    core_enable_d = '0;
    core_clear_d  = '0;
    busy_d        = busy_q;
    pend_d        = pend_q;
    rr_ptr_d      = rr_ptr_q;
    res_ptr_d     = res_ptr_q;
    core_tag_d    = core_tag_q;
    res_buf_d     = res_buf_q;
    res_valid_d   = res_valid_q;
    res_tag_d     = res_tag_q;
    res_value_d   = res_value_q;
    err_d         = err_q;
    fifo_pop      = 1'b0;

    // A core drops busy the cycle after its clear pulse.
    busy_d = busy_d & ~core_clear_q;

    // A core in its clear cycle is not yet free, so it cannot be re-targeted early.
    free_mask                = '0;
    free_mask[NUM_CORES-1:0] = ~busy_q & ~core_clear_q;
    disp_sel = rr_first(free_mask, SEL_W'(rr_ptr_q), NUM_CORES);
    disp_idx = CIW'(disp_sel.idx);
    if (!fifo_empty && disp_sel.found) begin
      fifo_pop                = 1'b1;
      core_enable_d[disp_idx] = 1'b1;
      core_tag_d[disp_idx]    = fifo_head;
      busy_d[disp_idx]        = 1'b1;
      rr_ptr_d                = CIW'((int'(disp_sel.idx) + 1) % NUM_CORES);
    end

    // Output register refills whenever it is empty or being drained.
    pend_mask                = '0;
    pend_mask[NUM_CORES-1:0] = pend_q;
    res_sel = rr_first(pend_mask, SEL_W'(res_ptr_q), NUM_CORES);
    res_idx = CIW'(res_sel.idx);
    if (!res_valid_q || res_ready) begin
      if (res_sel.found) begin
        res_valid_d           = 1'b1;
        res_tag_d             = core_tag_q[res_idx];
        res_value_d           = res_buf_q[res_idx];
        pend_d[res_idx]       = 1'b0;
        core_clear_d[res_idx] = 1'b1;
        res_ptr_d             = CIW'((int'(res_sel.idx) + 1) % NUM_CORES);
      end else begin
        res_valid_d = 1'b0;
      end
    end

    // Done on an allocated core is captured once; done on an idle core is an error.
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_done[i]) begin
        if (busy_q[i] && !pend_q[i]) begin
          res_buf_d[i] = core_val[i];
          pend_d[i]    = 1'b1;
        end else if (!busy_q[i]) begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_enable_q <= '0;
      core_clear_q  <= '0;
      busy_q        <= '0;
      pend_q        <= '0;
      rr_ptr_q      <= '0;
      res_ptr_q     <= '0;
      core_tag_q    <= '{default: '0};
      res_buf_q     <= '{default: '0};
      res_valid_q   <= 1'b0;
      res_tag_q     <= '0;
      res_value_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      core_enable_q <= core_enable_d;
      core_clear_q  <= core_clear_d;
      busy_q        <= busy_d;
      pend_q        <= pend_d;
      rr_ptr_q      <= rr_ptr_d;
      res_ptr_q     <= res_ptr_d;
      core_tag_q    <= core_tag_d;
      res_buf_q     <= res_buf_d;
      res_valid_q   <= res_valid_d;
      res_tag_q     <= res_tag_d;
      res_value_q   <= res_value_d;
      err_q         <= err_d;
    end
  end

  assign job_ready    = fifo_ready;
  assign core_enable  = core_enable_q;
  assign core_clear   = core_clear_q;
  assign busy         = busy_q;
  assign res_valid    = res_valid_q;
  assign res_tag      = res_tag_q;
  assign res_value    = res_value_q;
  assign err_spurious = err_q;

endmodule
